alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU interface for the TSP16 core. It accepts 16-bit instruction words from fetch over a valid/ready handshake and decodes register indices. It reads operands from an internal 8x16 register file and drives the combinational ALU's rn/rm/instr inputs. It then captures rd/z/n/v, writes the result back, and maintains the architectural status flags.

Parameters:
NREGS, 8, number of architectural registers (index width fixed at 3 bits)
RETIRE_W, 16, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  fetch presents instr_data
instr_data  input  16  instruction word
instr_ready  output  1  controller can accept an instruction this cycle
alu_rn  output  16  operand A to ALU
alu_rm  output  16  operand B to ALU
alu_instr  output  16  instruction word to ALU
alu_rd  input  16  ALU result (combinational from alu_* outputs)
alu_z  input  1  ALU zero flag
alu_n  input  1  ALU negative flag
alu_v  input  1  ALU overflow flag
flag_z  output  1  architectural Z
flag_n  output  1  architectural N
flag_v  output  1  architectural V
illegal  output  1  sticky: undefined opcode seen
retired  output  RETIRE_W  count of written-back instructions
dbg_addr  input  3  debug register read index
dbg_data  output  16  combinational read of regfile[dbg_addr] (index 0 reads 0)

Behaviour:
- Encoding uses the A_TYPE/R_TYPE and ALU op codes from Constant.sv.
- A-type: [15:14]=A_TYPE, [13:9]=op, [8:6]=rd, [5:3]=rn, [2:0]=rm.
- R-type: [15:14]=R_TYPE, [13:12]=ext (00 zext, 11 sext), [11:3]=imm9, [2:0]=rd.
- Other [15:14] values are illegal.
- r0 always reads 0. Writes to r0 are discarded but still count as retired.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch the word into ir and go to READ. Otherwise stay.
  - READ: register alu_rn=reg[ir rn], alu_rm=reg[ir rm], alu_instr=ir. For R-type, alu_rn=alu_rm=0. Go to EXEC.
  - EXEC: ALU outputs are stable. Capture alu_rd, alu_z, alu_n, alu_v into result registers. Decide legality:
    - Illegal: type not A/R; A-type op not in {ADD, EQUAL, OR, AND, MINUS}; R-type ext in {01, 10}.
    - Go to WB.
  - WB:
    - Legal: write result to reg[rd] and increment retired (wraps modulo 2^RETIRE_W).
    - A-type legal: flag_z/n/v <= captured flags.
    - R-type: flags unchanged.
    - Illegal: no register write, no flag change, no retire; illegal <= 1 (sticky until reset).
    - Go to IDLE.
- instr_ready is 0 in READ/EXEC/WB.
- Handshake at edge T: write visible at edge T+3. instr_ready high again in the cycle after T+3. Maximum throughput is 1 instruction per 4 cycles.
- Back-to-back dependent instructions need no forwarding: the write completes before the next READ.
- alu_rn/alu_rm/alu_instr are registered and hold their value outside READ.
- instr_data is ignored when instr_ready=0. Fetch must hold the word until accepted.
- Reset (async, any state): FSM->IDLE; all registers, alu_* outputs, flags, illegal and retired are 0.
  - An in-flight instruction is dropped with no write.
  - instr_ready is 0 while rst_n=0 and 1 in the first cycle after deassertion.
- Simultaneous dbg read of a register being written in WB returns the old value that cycle and the new value after the edge.

Test Plan:
- Reset, then R-type sext imm9=0x1F0 to r1 -> r1=0xFFF0; flags stay 000; retired=1.
- r1=0x7FFF and r2=0x0001 (via zext), then ADD r3=r1+r2 -> r3=0x8000, flag_n=1, flag_z=0, flag_v=1. Written at accept edge+3.
- r4=5, r5=5, MINUS r6=r4-r5 -> r6=0, flag_z=1. Follow immediately with ADD r7=r6+r4 (dependent) -> r7=5.
- Write to r0 with zext 0x1FF -> dbg_addr=0 reads 0; retired increments.
- Undefined A-type op code -> illegal=1, destination register, flags and retired unchanged. Next legal instruction still executes.
- Assert rst_n low during EXEC of an ADD to r3 -> r3 stays 0, FSM is in IDLE, instr_ready=1 one cycle after release. Also hold instr_valid with ready=0 for 3 cycles -> exactly one acceptance.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: TSP16 ALU issue controller with fetch handshake, 8x16 register file and status flags
module alu_issue_ctrl #(
  parameter int NREGS    = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [15:0]         instr_data,
  output logic                instr_ready,
  output logic [15:0]         alu_rn,
  output logic [15:0]         alu_rm,
  output logic [15:0]         alu_instr,
  input  logic [15:0]         alu_rd,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_v,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_v,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired,
  input  logic [2:0]          dbg_addr,
  output logic [15:0]         dbg_data
);
  localparam logic [1:0] A_TYPE   = 2'b00;
  localparam logic [1:0] R_TYPE   = 2'b01;
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_EQUAL = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_MINUS = 5'd4;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_nx;
  logic [15:0] ir, res;
  logic        res_z, res_n, res_v, bad;
  logic        is_a, is_r, legal;
  logic [2:0]  wb_addr;
  logic [15:0] regs [NREGS];

  always_comb begin
    is_a     = ir[15:14] == A_TYPE;
    is_r     = ir[15:14] == R_TYPE;
    legal    = is_a ? (ir[13:9] inside {OP_ADD, OP_EQUAL, OP_OR, OP_AND, OP_MINUS})
                    : is_r && (ir[13:12] == 2'b00 || ir[13:12] == 2'b11);
    wb_addr  = is_a ? ir[8:6] : ir[2:0];
    state_nx = state == IDLE ? (instr_valid ? READ : IDLE) :
               state == READ ? EXEC :
               state == EXEC ? WB : IDLE;
  end

  assign instr_ready = rst_n && state == IDLE;
  // r0 is never written, so it reads as zero everywhere
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ir        <= '0;
      res       <= '0;
      {res_z, res_n, res_v, bad} <= '0;
      {alu_rn, alu_rm, alu_instr} <= '0;
      {flag_z, flag_n, flag_v, illegal} <= '0;
      retired   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instr_valid) ir <= instr_data;
      if (state == READ) begin
        alu_rn    <= is_r ? 16'h0 : regs[ir[5:3]];
        alu_rm    <= is_r ? 16'h0 : regs[ir[2:0]];
        alu_instr <= ir;
      end
      if (state == EXEC) begin
        res   <= alu_rd;
        res_z <= alu_z;
        res_n <= alu_n;
        res_v <= alu_v;
        bad   <= !legal;
      end
      if (state == WB) begin
        if (bad) illegal <= 1'b1;
        else begin
          if (wb_addr != 3'd0) regs[wb_addr] <= res;
          retired <= retired + RETIRE_W'(1);
          if (is_a) {flag_z, flag_n, flag_v} <= {res_z, res_n, res_v};
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against an instruction-level model
module tb_alu_issue_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = '0;
  logic        instr_ready;
  logic [15:0] alu_rn, alu_rm, alu_instr, alu_rd;
  logic        alu_z, alu_n, alu_v;
  logic        flag_z, flag_n, flag_v, illegal;
  logic [15:0] retired;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  int          checks = 0, errors = 0;
  logic        rand_dbg = 1'b0;

  alu_issue_ctrl #(.NREGS(8), .RETIRE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_ready(instr_ready), .alu_rn(alu_rn), .alu_rm(alu_rm), .alu_instr(alu_instr),
    .alu_rd(alu_rd), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .illegal(illegal),
    .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Returns {v, n, z, result} for one instruction on operands a, b
  function automatic logic [18:0] alu_f(input logic [15:0] w, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        v;
    logic [8:0]  imm;
    r = '0; v = 1'b0; imm = w[11:3];
    if (w[15:14] == 2'b01) r = (w[13:12] == 2'b11) ? {{7{imm[8]}}, imm} : {7'b0, imm};
    else case (w[13:9])
      5'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      5'd1: r = (a == b) ? 16'd1 : 16'd0;
      5'd2: r = a | b;
      5'd3: r = a & b;
      5'd4: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      default: r = 16'hDEAD;
    endcase
    return {v, r[15], r == 16'h0, r};
  endfunction

  logic [18:0] alu_o;
  always_comb alu_o = alu_f(alu_instr, alu_rn, alu_rm);
  assign {alu_v, alu_n, alu_z, alu_rd} = alu_o;

  function automatic logic [15:0] a_w(input int op, input int rd, input int rn, input int rm);
    return {2'b00, 5'(op), 3'(rd), 3'(rn), 3'(rm)};
  endfunction
  function automatic logic [15:0] r_w(input int ext, input int imm, input int rd);
    return {2'b01, 2'(ext), 9'(imm), 3'(rd)};
  endfunction

  // Model: an accepted word takes effect three edges later; ready whenever nothing is in flight
  logic [15:0] m_r [8];
  logic [15:0] m_w;
  logic [2:0]  m_cnt, m_f;
  logic        m_ill;
  logic [15:0] m_ret;
  logic        m_isa, m_legal;
  logic [2:0]  m_rd;
  logic [18:0] m_o;

  always_comb begin
    m_isa   = m_w[15:14] == 2'b00;
    m_legal = m_isa ? (m_w[13:9] <= 5'd4) : (m_w[15:14] == 2'b01 && (m_w[13:12] == 2'b00 || m_w[13:12] == 2'b11));
    m_rd    = m_isa ? m_w[8:6] : m_w[2:0];
    m_o     = m_isa ? alu_f(m_w, m_r[m_w[5:3]], m_r[m_w[2:0]]) : alu_f(m_w, 16'h0, 16'h0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_r[i] <= '0;
      m_w <= '0; m_cnt <= '0; m_f <= '0; m_ill <= 1'b0; m_ret <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 3'd1;
      if (m_cnt == 3'd1) begin
        if (m_legal) begin
          if (m_rd != 3'd0) m_r[m_rd] <= m_o[15:0];
          m_ret <= m_ret + 16'd1;
          if (m_isa) m_f <= m_o[18:16];
        end else m_ill <= 1'b1;
      end
    end else if (instr_valid) begin
      m_w <= instr_data;
      m_cnt <= 3'd3;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) chk("ready_in_reset", instr_ready, 1'b0);
    else begin
      chk("ready", instr_ready, rst_n && m_cnt == 0);
      chk("flags_vnz", {flag_v, flag_n, flag_z}, m_f);
      chk("illegal", illegal, m_ill);
      chk("retired", retired, m_ret);
      chk("dbg_data", dbg_data, m_r[dbg_addr]);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_dbg) dbg_addr = 3'($urandom_range(0, 7));
  end

  task automatic issue(input logic [15:0] w, input int hold);
    int n = 0;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_data = w;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) chk("accept_timeout", instr_ready, 1'b1);
    @(posedge clk);
    repeat (hold) @(posedge clk);
    #1 instr_valid = 1'b0; instr_data = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (!instr_ready && n < 20);
    if (!instr_ready) chk("idle_timeout", instr_ready, 1'b1);
  endtask

  task automatic look(input int a, input logic [15:0] exp, input string nm);
    @(posedge clk); #1 dbg_addr = 3'(a);
    @(negedge clk);
    chk(nm, dbg_data, exp);
  endtask

  function automatic logic [15:0] rand_word();
    int t = $urandom_range(0, 9);
    if (t < 5) return a_w($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    if (t < 9) return r_w($urandom_range(0, 3), $urandom_range(0, 511), $urandom_range(0, 7));
    return {2'($urandom_range(2, 3)), 14'($urandom)};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", instr_ready, 1'b1);
    chk("reset_retired", retired, 16'd0);
    issue(r_w(3, 9'h1F0, 1), 0); wait_idle();
    look(1, 16'hFFF0, "sext_r1");
    chk("sext_flags", {flag_z, flag_n, flag_v}, 3'b000);
    chk("sext_retired", retired, 16'd1);
    issue(r_w(0, 9'hFF, 1), 0);
    repeat (7) issue(a_w(0, 1, 1, 1), 0);
    issue(r_w(0, 9'h7F, 2), 0);
    issue(a_w(0, 1, 1, 2), 0);
    issue(r_w(0, 1, 2), 0); wait_idle();
    look(1, 16'h7FFF, "r1_7fff");
    issue(a_w(0, 3, 1, 2), 0); wait_idle();
    look(3, 16'h8000, "add_ovf_r3");
    chk("add_ovf_flags_znv", {flag_z, flag_n, flag_v}, 3'b011);
    chk("retired_13", retired, 16'd13);
    issue(r_w(0, 5, 4), 0);
    issue(r_w(0, 5, 5), 0);
    issue(a_w(4, 6, 4, 5), 0); wait_idle();
    look(6, 16'h0000, "minus_r6");
    chk("minus_flags_znv", {flag_z, flag_n, flag_v}, 3'b100);
    issue(a_w(4, 6, 4, 5), 0);
    issue(a_w(0, 7, 6, 4), 0); wait_idle();
    look(7, 16'h0005, "dep_add_r7");
    issue(r_w(0, 9'h1FF, 0), 0); wait_idle();
    look(0, 16'h0000, "r0_zero");
    chk("r0_retired", retired, 16'd19);
    issue(a_w(9, 7, 1, 2), 0); wait_idle();
    chk("illegal_set", illegal, 1'b1);
    chk("illegal_retired", retired, 16'd19);
    look(7, 16'h0005, "illegal_r7_kept");
    issue(r_w(0, 3, 2), 0); wait_idle();
    look(2, 16'h0003, "after_illegal_r2");
    issue(r_w(0, 7, 5), 3); wait_idle();
    chk("hold_one_accept", retired, 16'd21);
    issue(a_w(0, 3, 1, 2), 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", instr_ready, 1'b1);
    chk("post_reset_retired", retired, 16'd0);
    look(3, 16'h0000, "dropped_r3");
    rand_dbg = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if ($urandom_range(0, 60) == 0) begin
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end
      issue(rand_word(), $urandom_range(0, 3) == 0 ? $urandom_range(1, 5) : 0);
    end
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
